// File: rtl/systolic_ctrl.sv
// Sequencing controller for an N x N systolic MAC array: clear, skewed operand feed, drain, capture.
// Optional build macro SYSTOLIC_CTRL_PERF_EN adds perf_cycles / perf_ops counters.
module systolic_ctrl #(
   parameter int N         = 4,
   parameter int KW        = 8,
   parameter int DRAIN_CYC = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [KW-1:0]     k_len,
   output logic              busy,
   output logic              pe_clear,
   output logic [N-1:0]      a_rd_en,
   output logic [N*KW-1:0]   a_rd_addr,
   output logic [N-1:0]      b_rd_en,
   output logic [N*KW-1:0]   b_rd_addr,
   output logic [N*N-1:0]    pe_valid,
   output logic              y_capture,
   output logic              done
`ifdef SYSTOLIC_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_cycles,
   output logic [15:0]       perf_ops
`endif
);

   // Step counter is wide enough for k = 2^KW-1 plus the full 2N-2 skew.
   localparam int TW  = KW + $clog2(2 * N) + 1;
   localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     t_q, t_d;
   logic [KW-1:0]     k_q, k_d;
   logic [DCW-1:0]    dc_q, dc_d;
   logic [TW-1:0]     t_last;

   logic              busy_q, busy_d;
   logic              clear_q, clear_d;
   logic [N-1:0]      a_en_q, a_en_d;
   logic [N*KW-1:0]   a_addr_q, a_addr_d;
   logic [N-1:0]      b_en_q, b_en_d;
   logic [N*KW-1:0]   b_addr_q, b_addr_d;
   logic [N*N-1:0]    valid_q, valid_d;
   logic              done_q, done_d;

`ifdef SYSTOLIC_CTRL_PERF_EN
   logic [31:0]       perf_cycles_q, perf_cycles_d;
   logic [15:0]       perf_ops_q, perf_ops_d;
`endif

   assign t_last = TW'(k_q) + TW'(2 * N - 3);

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      k_d     = k_q;
      dc_d    = dc_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_CLEAR;
               k_d     = k_len;
            end
         end
         ST_CLEAR: begin
            t_d     = '0;
            state_d = (k_q == '0) ? ST_DONE : ST_FEED;
         end
         ST_FEED: begin
            if (t_q == t_last) begin
               state_d = ST_DRAIN;
               dc_d    = '0;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         ST_DRAIN: begin
            if (dc_q == DCW'(DRAIN_CYC - 1)) state_d = ST_DONE;
            else                             dc_d    = dc_q + DCW'(1);
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      busy_d   = (state_d != ST_IDLE);
      clear_d  = (state_d == ST_CLEAR);
      done_d   = (state_d == ST_DONE);
      a_en_d   = '0;
      a_addr_d = '0;
      b_en_d   = '0;
      b_addr_d = '0;
      valid_d  = '0;
      if (state_d == ST_FEED) begin
         for (int i = 0; i < N; i++) begin
            if (t_d >= TW'(i) && t_d < TW'(i) + TW'(k_d)) begin
               a_en_d[i]              = 1'b1;
               a_addr_d[i*KW +: KW]   = KW'(t_d - TW'(i));
               b_en_d[i]              = 1'b1;
               b_addr_d[i*KW +: KW]   = KW'(t_d - TW'(i));
            end
         end
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if (t_d >= TW'(i + j) && t_d < TW'(i + j) + TW'(k_d))
                  valid_d[i*N + j] = 1'b1;
            end
         end
      end
   end

`ifdef SYSTOLIC_CTRL_PERF_EN
   always_comb begin
      perf_cycles_d = perf_cycles_q;
      perf_ops_d    = perf_ops_q;
      if (state_q == ST_IDLE && start && !abort) perf_cycles_d = '0;
      else if (state_q != ST_IDLE)               perf_cycles_d = perf_cycles_q + 32'd1;
      if (state_q == ST_DONE)                    perf_ops_d    = perf_ops_q + 16'd1;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         t_q      <= '0;
         k_q      <= '0;
         dc_q     <= '0;
         busy_q   <= 1'b0;
         clear_q  <= 1'b0;
         a_en_q   <= '0;
         a_addr_q <= '0;
         b_en_q   <= '0;
         b_addr_q <= '0;
         valid_q  <= '0;
         done_q   <= 1'b0;
`ifdef SYSTOLIC_CTRL_PERF_EN
         perf_cycles_q <= '0;
         perf_ops_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         k_q      <= k_d;
         dc_q     <= dc_d;
         busy_q   <= busy_d;
         clear_q  <= clear_d;
         a_en_q   <= a_en_d;
         a_addr_q <= a_addr_d;
         b_en_q   <= b_en_d;
         b_addr_q <= b_addr_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
`ifdef SYSTOLIC_CTRL_PERF_EN
         perf_cycles_q <= perf_cycles_d;
         perf_ops_q    <= perf_ops_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign pe_clear  = clear_q;
   assign a_rd_en   = a_en_q;
   assign a_rd_addr = a_addr_q;
   assign b_rd_en   = b_en_q;
   assign b_rd_addr = b_addr_q;
   assign pe_valid  = valid_q;
   assign y_capture = done_q;
   assign done      = done_q;
`ifdef SYSTOLIC_CTRL_PERF_EN
   assign perf_cycles = perf_cycles_q;
   assign perf_ops    = perf_ops_q;
`endif

endmodule
